chkn_eval_sched: RTL

Request scheduler and result buffer for the shared combinational chkn PLA (29 inputs x00..x28, 7 outputs z0..z6). NREQ requesters submit input vectors over valid/ready channels. A round-robin arbiter picks one vector per cycle and registers it onto the PLA inputs. The PLA outputs are captured into a small result FIFO and returned in order, tagged with requester id and tag, on one response channel.

---
 rtl/chkn_pkg.sv | 32 +++
 rtl/chkn_rr_arb.sv | 48 ++++
 rtl/chkn_eval_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/chkn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : chkn_pkg                                              |
// | Brief    : Shared widths, vector/entry types and FSM states for  |
// |            the chkn PLA request scheduler.                       |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package chkn_pkg;

  localparam int NX        = 29;  // PLA inputs x00..x28
  localparam int NZ        = 7;   // PLA outputs z0..z6
  localparam int ID_MAX_W  = 3;   // enough for up to 8 requesters
  localparam int TAG_MAX_W = 16;  // widest tag a FIFO entry can carry

  typedef logic [NX-1:0] x_t;
  typedef logic [NZ-1:0] z_t;

  // Result FIFO entry; id/tag are stored zero-extended to the max widths
  typedef struct packed {
    z_t                   z;
    logic [ID_MAX_W-1:0]  id;
    logic [TAG_MAX_W-1:0] tag;
  } fifo_ent_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/chkn_rr_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : chkn_rr_arb                                           |
// | Brief    : Combinational round-robin grant; search starts one    |
// |            past the last granted index.                          |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module chkn_rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_any,
  output logic [ID_W-1:0] rr_nxt
);

  int w_dist;
  int w_best;

  // Winner is the valid requester at the smallest circular distance after rr
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_dist  = 0;
    w_best  = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + 2 * NREQ - int'(rr) - 1) % NREQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        gnt_idx = ID_W'(i);
      end
    end
    gnt_any = (w_best < NREQ);
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = gnt_any && (gnt_idx == ID_W'(i));
    end
  end

  // Pointer only advances when the grant is actually taken
  assign rr_nxt = (en && gnt_any) ? gnt_idx : rr;

endmodule
`default_nettype wire

// File: rtl/chkn_eval_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : chkn_eval_sched                                       |
// | Brief    : Round-robin request scheduler in front of the shared  |
// |            chkn PLA, with an in-order tagged result FIFO.        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module chkn_eval_sched
  import chkn_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4,   // up to TAG_MAX_W
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NX-1:0]    req_x,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic                  pause,
  output logic [NX-1:0]         pla_x,
  input  logic [NZ-1:0]         pla_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NZ-1:0]         rsp_z,
  output logic [ID_W-1:0]       rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  busy,
  output logic [15:0]           eval_cnt
);

  localparam int AW = $clog2(DEPTH);

  // Stage S1 (drives the PLA)
  logic             r_s1_v;
  x_t               r_s1_x;
  logic [ID_W-1:0]  r_s1_id;
  logic [TAG_W-1:0] r_s1_tag;

  // Arbitration
  logic [ID_W-1:0]  r_rr;
  logic [ID_W-1:0]  w_rr_nxt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [NREQ-1:0]  w_gnt;
  logic             w_gnt_any;
  logic             w_can_issue;
  logic             w_accept;

  // Result FIFO
  fifo_ent_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_cnt_nxt;
  logic             w_push;
  logic             w_pop;
  fifo_ent_t        w_wr_ent;
  fifo_ent_t        w_head;
  logic [15:0]      r_eval_cnt;

  // Control FSM
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_work_nxt;

  // Credit ignores a same-cycle pop, so S1 always has a free slot to land in
  assign w_can_issue = !pause && ((int'(r_cnt) + int'(r_s1_v)) < DEPTH);

  chkn_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .rr      (r_rr),
    .en      (w_can_issue),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any),
    .rr_nxt  (w_rr_nxt)
  );

  assign req_ready = w_gnt & {NREQ{w_can_issue}};
  assign w_accept  = w_gnt_any && w_can_issue;

  // S1 load on accept; pla_x keeps its value otherwise so the PLA stays quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_x   <= '0;
      r_s1_id  <= '0;
      r_s1_tag <= '0;
      r_rr     <= ID_W'(NREQ - 1);
    end else begin
      r_s1_v <= w_accept;
      r_rr   <= w_rr_nxt;
      if (w_accept) begin
        r_s1_x   <= req_x[NX * int'(w_gnt_idx) +: NX];
        r_s1_id  <= w_gnt_idx;
        r_s1_tag <= req_tag[TAG_W * int'(w_gnt_idx) +: TAG_W];
      end
    end
  end

  assign pla_x     = r_s1_x;
  assign w_push    = r_s1_v;
  assign rsp_valid = (r_cnt != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_cnt_nxt = r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

  // Pack the PLA result with the S1 id/tag into a FIFO entry
  always_comb begin
    w_wr_ent     = '0;
    w_wr_ent.z   = pla_z;
    w_wr_ent.id  = ID_MAX_W'(r_s1_id);
    w_wr_ent.tag = TAG_MAX_W'(r_s1_tag);
  end

  // FIFO storage and pointers; memory is cleared so outputs read 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_eval_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_wr_ent;
        r_wp        <= r_wp + AW'(1);
        r_eval_cnt  <= r_eval_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  // Head slot is never written while valid and stalled, so rsp_* hold steady
  assign w_head   = r_mem[r_rp];
  assign rsp_z    = w_head.z;
  assign rsp_id   = w_head.id[ID_W-1:0];
  assign rsp_tag  = w_head.tag[TAG_W-1:0];
  assign eval_cnt = r_eval_cnt;

  // Work remains next cycle if S1 will be loaded or the FIFO will be non-empty
  assign w_work_nxt = w_accept || (w_cnt_nxt != '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: tracks whether work is outstanding and whether pause holds
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!w_work_nxt) w_state_nxt = ST_IDLE;
        else if (pause)  w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!w_work_nxt) w_state_nxt = ST_IDLE;
        else if (!pause) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
